// File: rtl/point_sequencer.sv
// point_sequencer: sweeps a bank of mass points through update_point each frame.
// Optional per-point watchdog enabled by defining SEQ_WATCHDOG_EN.
module point_sequencer #(
  parameter int NUM_POINTS      = 8,
  parameter int POSITION_SIZE   = 8,
  parameter int VELOCITY_SIZE   = 8,
  parameter int IDX_SIZE        = $clog2(NUM_POINTS),
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_start_in,
  input  logic                            load_in,
  input  logic [IDX_SIZE-1:0]             load_idx_in,
  input  logic signed [POSITION_SIZE-1:0] load_pos_x_in,
  input  logic signed [POSITION_SIZE-1:0] load_pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0] load_vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0] load_vel_y_in,
  output logic                            begin_out,
  output logic signed [POSITION_SIZE-1:0] pos_x_out,
  output logic signed [POSITION_SIZE-1:0] pos_y_out,
  output logic signed [VELOCITY_SIZE-1:0] vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0] vel_y_out,
  input  logic                            result_in,
  input  logic signed [POSITION_SIZE-1:0] new_pos_x_in,
  input  logic signed [POSITION_SIZE-1:0] new_pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0] new_vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0] new_vel_y_in,
  input  logic [IDX_SIZE-1:0]             rd_idx_in,
  output logic signed [POSITION_SIZE-1:0] rd_pos_x_out,
  output logic signed [POSITION_SIZE-1:0] rd_pos_y_out,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic [15:0]                     frame_count_out,
  output logic                            timeout_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [IDX_SIZE-1:0] LAST_IDX =
    IDX_SIZE'(NUM_POINTS - 1);
  localparam logic [IDX_SIZE:0] NUM_PTS =
    (IDX_SIZE + 1)'(NUM_POINTS);

  state_e              state_q, state_d;
  logic [IDX_SIZE-1:0] idx_q, idx_d;
  logic [15:0]         count_q, count_d;
  logic                advance;

  logic signed [POSITION_SIZE-1:0] px_q [NUM_POINTS];
  logic signed [POSITION_SIZE-1:0] px_d [NUM_POINTS];
  logic signed [POSITION_SIZE-1:0] py_q [NUM_POINTS];
  logic signed [POSITION_SIZE-1:0] py_d [NUM_POINTS];
  logic signed [VELOCITY_SIZE-1:0] vx_q [NUM_POINTS];
  logic signed [VELOCITY_SIZE-1:0] vx_d [NUM_POINTS];
  logic signed [VELOCITY_SIZE-1:0] vy_q [NUM_POINTS];
  logic signed [VELOCITY_SIZE-1:0] vy_d [NUM_POINTS];

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    advance = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load_in && ({1'b0, load_idx_in} < NUM_PTS)) begin
          px_d[load_idx_in] = load_pos_x_in;
          py_d[load_idx_in] = load_pos_y_in;
          vx_d[load_idx_in] = load_vel_x_in;
          vy_d[load_idx_in] = load_vel_y_in;
        end
        if (frame_start_in) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SEQ_WATCHDOG_EN
        wd_d = '0;
`endif
      end
      S_WAIT: begin
        // a result on the timeout edge wins over the watchdog
        if (result_in) begin
          px_d[idx_q] = new_pos_x_in;
          py_d[idx_q] = new_pos_y_in;
          vx_d[idx_q] = new_vel_x_in;
          vy_d[idx_q] = new_vel_y_in;
          advance     = 1'b1;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          advance   = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_SIZE'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
`ifdef SEQ_WATCHDOG_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign begin_out       = (state_q == S_ISSUE);
  assign busy_out        = (state_q != S_IDLE);
  assign frame_done_out  = (state_q == S_DONE);
  assign frame_count_out = count_q;

  assign pos_x_out = px_q[idx_q];
  assign pos_y_out = py_q[idx_q];
  assign vel_x_out = vx_q[idx_q];
  assign vel_y_out = vy_q[idx_q];

  assign rd_pos_x_out = ({1'b0, rd_idx_in} < NUM_PTS) ?
                        px_q[rd_idx_in] : '0;
  assign rd_pos_y_out = ({1'b0, rd_idx_in} < NUM_PTS) ?
                        py_q[rd_idx_in] : '0;

`ifdef SEQ_WATCHDOG_EN
  assign timeout_out = timeout_q;
`else
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_point_sequencer.sv
// tb_point_sequencer: scoreboard bench with an update_point stub.
// Watchdog scenario runs only when SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_point_sequencer;
  localparam int N  = 8;
  localparam int WD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, frame_start_in, load_in, result_in;
  logic [2:0] load_idx_in, rd_idx_in;
  logic signed [7:0] load_pos_x_in, load_pos_y_in;
  logic signed [7:0] load_vel_x_in, load_vel_y_in;
  logic signed [7:0] new_pos_x_in, new_pos_y_in;
  logic signed [7:0] new_vel_x_in, new_vel_y_in;
  logic begin_out, busy_out, frame_done_out, timeout_out;
  logic signed [7:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
  logic signed [7:0] rd_pos_x_out, rd_pos_y_out;
  logic [15:0] frame_count_out;

  point_sequencer #(
    .NUM_POINTS(N), .POSITION_SIZE(8), .VELOCITY_SIZE(8),
    .IDX_SIZE(3), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk_in(clk), .rst_in(rst_in),
    .frame_start_in(frame_start_in), .load_in(load_in),
    .load_idx_in(load_idx_in),
    .load_pos_x_in(load_pos_x_in), .load_pos_y_in(load_pos_y_in),
    .load_vel_x_in(load_vel_x_in), .load_vel_y_in(load_vel_y_in),
    .begin_out(begin_out),
    .pos_x_out(pos_x_out), .pos_y_out(pos_y_out),
    .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
    .result_in(result_in),
    .new_pos_x_in(new_pos_x_in), .new_pos_y_in(new_pos_y_in),
    .new_vel_x_in(new_vel_x_in), .new_vel_y_in(new_vel_y_in),
    .rd_idx_in(rd_idx_in),
    .rd_pos_x_out(rd_pos_x_out), .rd_pos_y_out(rd_pos_y_out),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .frame_count_out(frame_count_out), .timeout_out(timeout_out)
  );

  typedef struct packed {
    logic [7:0] x, y, vx, vy;
  } pt_t;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit exp_timeout = 0;
  logic signed [7:0] mx [N];
  logic signed [7:0] my [N];
  logic signed [7:0] mvx [N];
  logic signed [7:0] mvy [N];
  pt_t sb [$];

  task automatic model_clear;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_idx_in = 3'(i);
      #1;
      checks++;
      if (rd_pos_x_out !== mx[i] || rd_pos_y_out !== my[i]) begin
        errors++;
        $display("FAIL %s bank[%0d]: got (%0d,%0d) want (%0d,%0d)",
                 tag, i, rd_pos_x_out, rd_pos_y_out, mx[i], my[i]);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({begin_out, busy_out, frame_done_out} !== 3'b000 ||
        timeout_out !== exp_timeout ||
        frame_count_out !== 16'(exp_count)) begin
      errors++;
      $display("FAIL %s status: got b%0d y%0d d%0d t%0d c%0d want 0 0 0 %0d %0d",
               tag, begin_out, busy_out, frame_done_out, timeout_out,
               frame_count_out, exp_timeout, exp_count);
    end
    checks++;
    if ({pos_x_out, pos_y_out, vel_x_out, vel_y_out} !== 32'h0) begin
      errors++;
      $display("FAIL %s operands: got %h want 0", tag,
               {pos_x_out, pos_y_out, vel_x_out, vel_y_out});
    end
  endtask

  task automatic do_load(input int idx, input logic signed [7:0] x,
                         input logic signed [7:0] y,
                         input logic signed [7:0] vx,
                         input logic signed [7:0] vy);
    @(negedge clk);
    load_in = 1; load_idx_in = 3'(idx);
    load_pos_x_in = x; load_pos_y_in = y;
    load_vel_x_in = vx; load_vel_y_in = vy;
    mx[idx] = x; my[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
    @(negedge clk);
    load_in = 0;
  endtask

  task automatic run_frame(input string tag, input int lat,
                           input int silent, input bit ld,
                           input logic signed [7:0] lx,
                           input logic signed [7:0] ly,
                           input bit noise);
    int cyc, begins, dones, wcnt, cur, last_res;
    bit active, fin;
    pt_t e;
    cyc = 0; begins = 0; dones = 0; wcnt = 0;
    cur = -1; last_res = -100; active = 0; fin = 0;
    e = '0;
    @(negedge clk);
    frame_start_in = 1;
    if (ld) begin
      load_in = 1; load_idx_in = 0;
      load_pos_x_in = lx; load_pos_y_in = ly;
      load_vel_x_in = 8'sd1; load_vel_y_in = 8'sd2;
      mx[0] = lx; my[0] = ly; mvx[0] = 8'sd1; mvy[0] = 8'sd2;
    end
    sb.delete();
    for (int i = 0; i < N; i++)
      sb.push_back({mx[i], my[i], mvx[i], mvy[i]});
    while (!fin && cyc < 600) begin
      @(negedge clk);
      cyc++;
      frame_start_in = 0; load_in = 0; result_in = 0;
      if (begin_out) begin
`ifdef SEQ_WATCHDOG_EN
        if (silent >= 0 && cur == silent) begin
          checks++;
          if (wcnt !== WD) begin
            errors++;
            $display("FAIL %s skip_wait: got %0d want %0d",
                     tag, wcnt, WD);
          end
        end
`endif
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_begin: got %0d want %0d",
                   tag, begins + 1, N);
        end else begin
          e = sb.pop_front();
          if ({pos_x_out, pos_y_out, vel_x_out, vel_y_out} !== e) begin
            errors++;
            $display("FAIL %s issue[%0d]: got %h want %h", tag, begins,
                     {pos_x_out, pos_y_out, vel_x_out, vel_y_out}, e);
          end
        end
        begins++; cur = begins - 1; wcnt = 0; active = 1;
      end else if (active) begin
        wcnt++;
        checks++;
        if ({pos_x_out, pos_y_out, vel_x_out, vel_y_out} !== e) begin
          errors++;
          $display("FAIL %s hold[%0d]: got %h want %h", tag, cur,
                   {pos_x_out, pos_y_out, vel_x_out, vel_y_out}, e);
        end
        if (noise && cur == 2 && wcnt == 1) begin
          frame_start_in = 1; load_in = 1; load_idx_in = 3'd5;
          load_pos_x_in = 8'sh55; load_pos_y_in = 8'sh55;
          load_vel_x_in = 8'sh55; load_vel_y_in = 8'sh55;
        end
        if (wcnt == lat && cur != silent) begin
          result_in = 1;
          mx[cur] = mx[cur] - 8'sd1;
          new_pos_x_in = mx[cur]; new_pos_y_in = my[cur];
          new_vel_x_in = mvx[cur]; new_vel_y_in = mvy[cur];
          active = 0; last_res = cyc;
        end
      end
      if (frame_done_out) begin
        dones++;
        checks++;
        if (cyc !== last_res + 1) begin
          errors++;
          $display("FAIL %s done_timing: got cyc %0d want %0d",
                   tag, cyc, last_res + 1);
        end
      end
      if (dones > 0 && !busy_out) fin = 1;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s sweep_end: got no end want end in 600 cycles",
               tag);
    end
    exp_count++;
    checks++;
    if (begins !== N || dones !== 1) begin
      errors++;
      $display("FAIL %s pulses: got begins %0d dones %0d want %0d 1",
               tag, begins, dones, N);
    end
    checks++;
    if (frame_count_out !== 16'(exp_count) ||
        timeout_out !== exp_timeout) begin
      errors++;
      $display("FAIL %s count: got %0d t%0d want %0d t%0d", tag,
               frame_count_out, timeout_out, exp_count, exp_timeout);
    end
    check_bank(tag);
  endtask

  task automatic test_reset;
    rst_in = 0;
    repeat (2) @(negedge clk);
    model_clear();
    exp_count = 0; exp_timeout = 0;
    check_idle("reset");
    check_bank("reset");
    rst_in = 1;
  endtask

  task automatic test_frame;
    do_load(2, 8'sd2, 8'sd3, -8'sd2, 8'sd0);
    run_frame("frame", 5, -1, 0, 0, 0, 0);
    rd_idx_in = 3'd2;
    #1;
    checks++;
    if (rd_pos_x_out !== 8'sd1 || rd_pos_y_out !== 8'sd3) begin
      errors++;
      $display("FAIL frame_p2: got (%0d,%0d) want (1,3)",
               rd_pos_x_out, rd_pos_y_out);
    end
  endtask

  task automatic test_load_start;
    run_frame("load_start", 2, -1, 1, 8'sd7, -8'sd7, 0);
  endtask

  task automatic test_ignore;
    run_frame("ignore", 3, -1, 0, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (begin_out !== 1'b0 || busy_out !== 1'b0) begin
        errors++;
        $display("FAIL ignore_idle: got b%0d y%0d want 0 0",
                 begin_out, busy_out);
      end
    end
  endtask

`ifdef SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    checks++;
    if (timeout_out !== 1'b0) begin
      errors++;
      $display("FAIL wd_pre: got %0d want 0", timeout_out);
    end
    exp_timeout = 1;
    run_frame("watchdog", 2, 1, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_reset_mid;
    int cyc, begins, wcnt;
    bit hit;
    cyc = 0; begins = 0; wcnt = 0; hit = 0;
    @(negedge clk);
    frame_start_in = 1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      frame_start_in = 0; result_in = 0;
      if (begin_out) begin
        begins++; wcnt = 0;
        if (begins == 4) hit = 1;
      end else begin
        wcnt++;
        if (wcnt == 2) begin
          result_in = 1;
          new_pos_x_in = 8'sd9; new_pos_y_in = 8'sd9;
          new_vel_x_in = 8'sd9; new_vel_y_in = 8'sd9;
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: got %0d begins want 4", begins);
    end
    @(negedge clk);
    rst_in = 0;
    @(negedge clk);
    rst_in = 1; result_in = 1;
    new_pos_x_in = 8'sd33; new_pos_y_in = 8'sd33;
    new_vel_x_in = 8'sd33; new_vel_y_in = 8'sd33;
    @(negedge clk);
    result_in = 0;
    model_clear();
    exp_count = 0; exp_timeout = 0;
    check_idle("reset_mid");
    check_bank("reset_mid");
  endtask

  task automatic test_back_to_back;
    run_frame("b2b_a", 1, -1, 0, 0, 0, 0);
    run_frame("b2b_b", 1, -1, 0, 0, 0, 0);
  endtask

  initial begin
    rst_in = 0; frame_start_in = 0; load_in = 0; result_in = 0;
    load_idx_in = 0; rd_idx_in = 0;
    load_pos_x_in = 0; load_pos_y_in = 0;
    load_vel_x_in = 0; load_vel_y_in = 0;
    new_pos_x_in = 0; new_pos_y_in = 0;
    new_vel_x_in = 0; new_vel_y_in = 0;
    model_clear();
    test_reset();
    test_frame();
    test_load_start();
    test_ignore();
`ifdef SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
